// File: rtl/seq_check.sv
// Compares an N-bit per-cycle stream against an ASCII expected-pattern string.
// Build option: define SEQ_CHECK_CONTINUE_EN to run all PLEN chars instead of stopping at the first mismatch.
module seq_check #(
    parameter logic [1023:0] PATTERN = '0,
    parameter int            PLEN    = 1,
    parameter int            N       = 1
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         start,
    input  logic         din_valid,
    input  logic [N-1:0] din,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         fail,
    output logic [7:0]   pos,
    output logic [7:0]   err_pos,
    output logic [7:0]   err_cnt
);

`ifdef SEQ_CHECK_CONTINUE_EN
    localparam bit CONTINUE_ON_ERR = 1'b1;
`else
    localparam bit CONTINUE_ON_ERR = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Number of non-NUL chars in PATTERN; a string literal is right-justified,
    // so its leftmost char sits in the highest occupied byte.
    function automatic int str_len(input logic [1023:0] s);
        int len;
        len = 0;
        for (int i = 0; i < 128; i++) begin
            if (s[8*i +: 8] != 8'h00) len = i + 1;
        end
        return len;
    endfunction

    // Returns {care, value}; care=0 marks a don't-care char.
    function automatic logic [4:0] decode_char(input logic [7:0] c);
        if (c >= "0" && c <= "9") return {1'b1, c[3:0]};
        if ((c >= "a" && c <= "f") || (c >= "A" && c <= "F")) return {1'b1, c[3:0] + 4'd9};
        if (c == "_") return 5'b1_0000;
        if (c == "-") return 5'b1_1111;
        return 5'b0_0000;
    endfunction

    localparam int         SLEN     = str_len(PATTERN);
    localparam logic [7:0] LAST_POS = 8'(PLEN - 1);
    localparam bit         EMPTY    = (PLEN == 0);

    // NOTE: the decode table is elaboration-time constant logic, not storage,
    // so it needs no reset; 256 entries match the 8-bit pos index exactly.
    logic [4:0] w_table [256];

    for (genvar i = 0; i < 256; i++) begin : g_tab
        if (i < PLEN && i < SLEN) begin : g_chr
            assign w_table[i] = decode_char(PATTERN[8*(SLEN-1-i) +: 8]);
        end else begin : g_dc
            assign w_table[i] = 5'b0_0000;
        end
    end

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_pos;
    logic [7:0] r_err_pos;
    logic [7:0] r_err_cnt;
    logic       r_pass;
    logic       r_fail;

    logic [4:0]   w_entry;
    logic [N-1:0] w_exp;
    logic         w_mismatch;
    logic         w_beat;
    logic         w_stop;
    logic         w_finish;

    assign w_entry    = w_table[r_pos];
    assign w_exp      = w_entry[N-1:0];
    assign w_mismatch = w_entry[4] && (din != w_exp);
    // start takes priority over a beat arriving in the same cycle
    assign w_beat     = (r_state == S_RUN) && din_valid && !start;
    assign w_stop     = w_mismatch && !CONTINUE_ON_ERR;
    assign w_finish   = w_beat && ((r_pos == LAST_POS) || w_stop);

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: ;
            S_RUN: begin
                busy = 1'b1;
                if (w_finish) w_next_state = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        if (start) w_next_state = EMPTY ? S_DONE : S_RUN;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pos     <= 8'd0;
            r_err_pos <= 8'd0;
            r_err_cnt <= 8'd0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
        end else if (start) begin
            r_pos     <= 8'd0;
            r_err_pos <= 8'd0;
            r_err_cnt <= 8'd0;
            r_pass    <= EMPTY;
            r_fail    <= 1'b0;
        end else if (w_beat) begin
            if (w_mismatch) begin
                if (r_err_cnt == 8'd0) r_err_pos <= r_pos;
                if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            end
            // a stopping mismatch freezes pos at the offending index
            if (!w_stop) r_pos <= r_pos + 8'd1;
            if (w_finish) begin
                r_fail <= w_mismatch || (r_err_cnt != 8'd0);
                r_pass <= !(w_mismatch || (r_err_cnt != 8'd0));
            end
        end
    end

    assign pos     = r_pos;
    assign err_pos = r_err_pos;
    assign err_cnt = r_err_cnt;
    assign pass    = r_pass;
    assign fail    = r_fail;

endmodule
